// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port round-robin SRAM arbiter.
// The optional post-reset zero-fill is enabled by defining SRAM_ARB_INIT_EN.
package sram_arb_pkg;

   localparam int NREQ       = 2;
   localparam int ADDR_W_DEF = 8;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef logic req_id_t;

   function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester always wins, on contention
// the requester named by the pointer wins, and the pointer then moves away.
module sram_rr_arb2
   import sram_arb_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic [NREQ-1:0] valid_i,
   output logic [NREQ-1:0] grant_o,
   output req_id_t         grant_id_o,
   output req_id_t         ptr_o
);

   req_id_t ptr_q, ptr_d;

   always_comb begin
      grant_o    = '0;
      grant_id_o = 1'b0;
      if (en_i) begin
         case (valid_i)
            2'b01: begin
               grant_o    = 2'b01;
               grant_id_o = 1'b0;
            end
            2'b10: begin
               grant_o    = 2'b10;
               grant_id_o = 1'b1;
            end
            2'b11: begin
               grant_o    = id_onehot(ptr_q);
               grant_id_o = ptr_q;
            end
            default: ;
         endcase
      end
   end

   // The winner loses priority for the next contended cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (|grant_o) begin
         ptr_d = ~grant_id_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Shares one single-port RW SRAM macro between two requesters, round-robin.
// Define SRAM_ARB_INIT_EN to zero-fill the whole array after every reset.
module sram_rw_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = 128,
   parameter int MASK_W = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*MASK_W-1:0]   req_wmask,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     mem_en,
   output logic                     mem_wmode,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [MASK_W-1:0]        mem_wmask,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     init_done,
   output state_e                   dbg_state
);

   state_e            state_q;
   logic              init_active;
   logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_ARB_INIT_EN
   state_e            state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              init_done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (cnt_q == '1) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= (state_d == RUN);
      end
   end

   assign init_active = (state_q == INIT) && !reset;
   assign init_addr   = cnt_q;
   assign init_done   = init_done_q;
`else
   assign state_q     = RUN;
   assign init_active = 1'b0;
   assign init_addr   = '0;
   assign init_done   = 1'b1;
`endif

   assign dbg_state = state_q;

   // Handshake: a request transfers in a cycle where req_valid[i] & req_ready[i].
   // req_ready is a combinational function of req_valid; valid must never wait
   // on ready. Read responses have no backpressure and arrive exactly one cycle
   // after the transfer.
   logic            run_en;
   logic [NREQ-1:0] grant;
   req_id_t         grant_id;
   req_id_t         rr_ptr;

   assign run_en = (state_q == RUN) && !reset;

   sram_rr_arb2 u_arb (
      .clk_i      (clock),
      .rst_i      (reset),
      .en_i       (run_en),
      .valid_i    (req_valid),
      .grant_o    (grant),
      .grant_id_o (grant_id),
      .ptr_o      (rr_ptr)
   );

   assign req_ready = grant;

   logic [ADDR_W-1:0] addr_a  [NREQ];
   logic [MASK_W-1:0] wmask_a [NREQ];
   logic [DATA_W-1:0] wdata_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wmask_a[i] = req_wmask[i*MASK_W +: MASK_W];
      assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_wmode = 1'b0;
      mem_addr  = '0;
      mem_wmask = '0;
      mem_wdata = '0;
      if (init_active) begin
         mem_en    = 1'b1;
         mem_wmode = 1'b1;
         mem_addr  = init_addr;
         mem_wmask = '1;
      end else if (|grant) begin
         mem_en    = 1'b1;
         mem_wmode = req_write[grant_id];
         mem_addr  = addr_a[grant_id];
         mem_wmask = wmask_a[grant_id];
         mem_wdata = wdata_a[grant_id];
      end
   end

   logic    rsp_pend_q, rsp_pend_d;
   req_id_t rsp_id_q;

   assign rsp_pend_d = (|grant) && !req_write[grant_id];

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_pend_q <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         rsp_pend_q <= rsp_pend_d;
         rsp_id_q   <= grant_id;
      end
   end

   // Macro output is only meaningful the cycle after a read; mask it otherwise.
   logic rsp_live;
   assign rsp_live  = rsp_pend_q && !reset;
   assign rsp_valid = rsp_live ? id_onehot(rsp_id_q) : '0;
   assign rsp_rdata = rsp_live ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural 1-cycle SRAM.
// Covers both builds; define SRAM_ARB_INIT_EN to exercise the zero-fill path.
module tb_sram_rw_port_arbiter;
   import sram_arb_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 128;
   localparam int MASK_W = 4;
   localparam int LANE_W = DATA_W / MASK_W;

   logic                   clock;
   logic                   reset;
   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0]             req_write;
   logic [2*ADDR_W-1:0]    req_addr;
   logic [2*MASK_W-1:0]    req_wmask;
   logic [2*DATA_W-1:0]    req_wdata;
   logic [1:0]             rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;
   logic                   mem_en;
   logic                   mem_wmode;
   logic [ADDR_W-1:0]      mem_addr;
   logic [MASK_W-1:0]      mem_wmask;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;
   logic                   init_done;
   state_e                 dbg_state;

   int checks;
   int errors;

   sram_rw_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MASK_W (MASK_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wmask (req_wmask),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_wmode (mem_wmode),
      .mem_addr  (mem_addr),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .init_done (init_done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural SRAM macro ----------------
   logic [DATA_W-1:0] sram [0:DEPTH-1];

   always @(posedge clock) begin
      if (mem_en && mem_wmode) begin
         for (int l = 0; l < MASK_W; l++) begin
            if (mem_wmask[l]) sram[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
         end
      end
      if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
      else                      mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [1:0] v, input logic [1:0] w,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [MASK_W-1:0] m0, input logic [MASK_W-1:0] m1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
      req_valid = v;
      req_write = w;
      req_addr  = {a1, a0};
      req_wmask = {m1, m0};
      req_wdata = {d1, d0};
   endtask

   task automatic idle;
      drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      @(negedge clock);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic exp_done;
`ifdef SRAM_ARB_INIT_EN
      exp_done = 1'b0;
`else
      exp_done = 1'b1;
`endif
      reset = 1'b1;
      drive(2'b11, 2'b00, 8'h05, 8'h06, '0, '0, '0, '0);
      next_cycle;
      next_cycle;
      settle;
      checks++;
      if (req_ready !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b exp 00", req_ready);
      end
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid);
      end
      checks++;
      if (rsp_rdata !== '0) begin
         errors++; $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata);
      end
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL reset_mem_en: got %b exp 0", mem_en);
      end
      checks++;
      if (init_done !== exp_done) begin
         errors++; $display("FAIL reset_init_done: got %b exp %b", init_done, exp_done);
      end
      next_cycle;
   endtask

   // Releases reset with both requesters valid; leaves pointer favouring req1.
   task automatic test_startup;
      reset = 1'b0;
      drive(2'b11, 2'b00, 8'h37, 8'h38, '0, '0, '0, '0);
`ifdef SRAM_ARB_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
         settle;
         checks++;
         if (req_ready !== 2'b00 || mem_en !== 1'b1 || mem_wmode !== 1'b1 ||
             mem_addr !== 8'(i) || mem_wmask !== 4'hF || mem_wdata !== '0 ||
             init_done !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL init_cycle_%0d: ready=%b en=%b wmode=%b addr=%h mask=%h data_nz=%b done=%b rsp=%b exp ready=00 en=1 wmode=1 addr=%h mask=f data_nz=0 done=0 rsp=00",
                     i, req_ready, mem_en, mem_wmode, mem_addr, mem_wmask, |mem_wdata, init_done, rsp_valid, 8'(i));
         end
         next_cycle;
      end
`endif
      settle;
      checks++;
      if (init_done !== 1'b1) begin
         errors++; $display("FAIL startup_init_done: got %b exp 1", init_done);
      end
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL startup_ready: got %b exp 01", req_ready);
      end
      checks++;
      if (dbg_state !== RUN) begin
         errors++; $display("FAIL startup_state: got %0d exp %0d", dbg_state, RUN);
      end
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++; $display("FAIL startup_no_rsp: got %b exp 00", rsp_valid);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_wmode !== 1'b0 || mem_addr !== 8'h37) begin
         errors++; $display("FAIL startup_mem: en=%b wmode=%b addr=%h exp en=1 wmode=0 addr=37", mem_en, mem_wmode, mem_addr);
      end
      next_cycle;
      idle;
      settle;
      checks++;
      if (rsp_valid !== 2'b01) begin
         errors++; $display("FAIL startup_rsp_valid: got %b exp 01", rsp_valid);
      end
`ifdef SRAM_ARB_INIT_EN
      checks++;
      if (rsp_rdata !== '0) begin
         errors++; $display("FAIL startup_zero_fill: got %h exp 0", rsp_rdata);
      end
`endif
      next_cycle;
   endtask

   task automatic test_single;
      logic [DATA_W-1:0] pat;
      pat = {16{8'hA5}};
      drive(2'b01, 2'b01, 8'h10, '0, 4'hF, '0, pat, '0);
      settle;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL single_wr_ready: got %b exp 01", req_ready);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_wmode !== 1'b1 || mem_addr !== 8'h10 || mem_wmask !== 4'hF || mem_wdata !== pat) begin
         errors++; $display("FAIL single_wr_mem: en=%b wmode=%b addr=%h mask=%h data=%h", mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata);
      end
      next_cycle;
      drive(2'b01, 2'b00, 8'h10, '0, '0, '0, '0, '0);
      settle;
      checks++;
      if (req_ready !== 2'b01 || mem_en !== 1'b1 || mem_wmode !== 1'b0 || mem_addr !== 8'h10) begin
         errors++; $display("FAIL single_rd_mem: ready=%b en=%b wmode=%b addr=%h exp 01 1 0 10", req_ready, mem_en, mem_wmode, mem_addr);
      end
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++; $display("FAIL single_wr_no_rsp: got %b exp 00", rsp_valid);
      end
      next_cycle;
      idle;
      settle;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL single_idle_mem_en: got %b exp 0", mem_en);
      end
      checks++;
      if (rsp_valid !== 2'b01) begin
         errors++; $display("FAIL single_rsp_valid: got %b exp 01", rsp_valid);
      end
      checks++;
      if (rsp_rdata !== pat) begin
         errors++; $display("FAIL single_rsp_rdata: got %h exp %h", rsp_rdata, pat);
      end
      next_cycle;
      settle;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== '0) begin
         errors++; $display("FAIL single_no_leak: valid=%b rdata=%h exp 00 0", rsp_valid, rsp_rdata);
      end
      next_cycle;
   endtask

   task automatic test_contention;
      logic [DATA_W-1:0] d1, d2;
      logic [1:0]        exp_g;
      logic [1:0]        prev_g;
      logic [ADDR_W-1:0] exp_a;
      d1 = {4{32'hC0DE_0001}};
      d2 = {4{32'hBEEF_0002}};
      prev_g = 2'b00;
      drive(2'b01, 2'b01, 8'h01, '0, 4'hF, '0, d1, '0);
      next_cycle;
      drive(2'b10, 2'b10, '0, 8'h02, '0, 4'hF, '0, d2);
      next_cycle;
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, 2'b00, 8'h01, 8'h02, '0, '0, '0, '0);
         settle;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (k % 2 == 0) ? 8'h01 : 8'h02;
         checks++;
         if (req_ready !== exp_g) begin
            errors++; $display("FAIL contend_grant_%0d: got %b exp %b", k, req_ready, exp_g);
         end
         checks++;
         if (mem_addr !== exp_a || mem_en !== 1'b1) begin
            errors++; $display("FAIL contend_addr_%0d: addr=%h en=%b exp %h 1", k, mem_addr, mem_en, exp_a);
         end
         if (k > 0) begin
            checks++;
            if (rsp_valid !== prev_g || rsp_rdata !== (prev_g == 2'b01 ? d1 : d2)) begin
               errors++; $display("FAIL contend_rsp_%0d: valid=%b rdata=%h exp %b %h", k, rsp_valid, rsp_rdata, prev_g, (prev_g == 2'b01 ? d1 : d2));
            end
         end
         prev_g = exp_g;
         next_cycle;
      end
      idle;
      settle;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== d2) begin
         errors++; $display("FAIL contend_last_rsp: valid=%b rdata=%h exp 10 %h", rsp_valid, rsp_rdata, d2);
      end
      next_cycle;
   endtask

   task automatic test_partial_mask;
      logic [DATA_W-1:0] exp_d;
      exp_d = 128'h11111111_22222222_11111111_11111111;
      drive(2'b01, 2'b01, 8'h20, '0, 4'hF, '0, {4{32'h11111111}}, '0);
      next_cycle;
      drive(2'b10, 2'b10, '0, 8'h20, '0, 4'b0100, '0, {4{32'h22222222}});
      settle;
      checks++;
      if (mem_wmask !== 4'b0100 || mem_addr !== 8'h20 || mem_wmode !== 1'b1) begin
         errors++; $display("FAIL mask_mem: mask=%b addr=%h wmode=%b exp 0100 20 1", mem_wmask, mem_addr, mem_wmode);
      end
      next_cycle;
      drive(2'b01, 2'b00, 8'h20, '0, '0, '0, '0, '0);
      next_cycle;
      idle;
      settle;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== exp_d) begin
         errors++; $display("FAIL mask_rdata: valid=%b rdata=%h exp 01 %h", rsp_valid, rsp_rdata, exp_d);
      end
      next_cycle;
   endtask

   task automatic test_reset_mid;
      drive(2'b01, 2'b00, 8'h10, '0, '0, '0, '0, '0);
      next_cycle;
      reset = 1'b1;
      drive(2'b11, 2'b00, 8'h37, 8'h38, '0, '0, '0, '0);
      settle;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== '0) begin
         errors++; $display("FAIL midreset_rsp: valid=%b rdata=%h exp 00 0", rsp_valid, rsp_rdata);
      end
      checks++;
      if (req_ready !== 2'b00 || mem_en !== 1'b0) begin
         errors++; $display("FAIL midreset_ready: ready=%b en=%b exp 00 0", req_ready, mem_en);
      end
      next_cycle;
      test_startup;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle;
      test_reset;
      test_startup;
      test_single;
      test_contention;
      test_partial_mask;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
